// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives ALU op, operand selects and datapath strobes from the state register.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MADDR   = 4'd2;
  localparam logic [3:0] S_MREAD   = 4'd3;
  localparam logic [3:0] S_MWB     = 4'd4;
  localparam logic [3:0] S_MWRITE  = 4'd5;
  localparam logic [3:0] S_REXEC   = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_IEXEC   = 4'd10;
  localparam logic [3:0] S_IWB     = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [3:0] state_q, state_d;
  logic       is_lw, is_sw, is_r, is_beq, is_j, is_addi;
  logic       r_ok;
  logic [3:0] r_alu;

  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_r    = (opcode == 6'b000000);
  assign is_beq  = (opcode == 6'b000100);
  assign is_j    = (opcode == 6'b000010);
  assign is_addi = (opcode == 6'b001000);

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_AND;
    case (funct)
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b101010: r_alu = ALU_SLT;
      6'b100111: r_alu = ALU_NOR;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_lw | is_sw: state_d = S_MADDR;
          is_r & r_ok:   state_d = S_REXEC;
          is_beq:        state_d = S_BRANCH;
          is_j:          state_d = S_JUMP;
          is_addi:       state_d = S_IEXEC;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MADDR:  state_d = is_lw ? S_MREAD : S_MWRITE;
      S_MREAD:  state_d = mem_ready ? S_MWB : S_MREAD;
      S_MWRITE: state_d = mem_ready ? S_FETCH : S_MWRITE;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_control = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      S_MADDR, S_IEXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MREAD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MWRITE: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
      end
      S_RWB: begin
        alu_control = r_alu;
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        instr_done  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = zero;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_IWB: begin
        alu_control = ALU_ADD;
        reg_write   = 1'b1;
        instr_done  = 1'b1;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset wins over any in-flight instruction so nothing is committed
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule
